// File: rtl/morse_text_pkg.sv
// rtl/morse_text_pkg.sv - shared constants and helpers for the Morse text line overlay
package morse_text_pkg;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_MIN   = 8'h20;
    localparam logic [7:0] ASCII_MAX   = 8'h7E;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    localparam logic [11:0] DEFAULT_FG  = 12'h00F;
    localparam logic [11:0] DEFAULT_BG  = 12'hFFF;
    localparam logic [11:0] COLOR_BLACK = 12'h000;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= ASCII_MIN) && (code <= ASCII_MAX);
    endfunction

endpackage

// File: rtl/ascii_rom.sv
// rtl/ascii_rom.sv - 8x16 glyph source, address {code[6:0], row[3:0]}, one clock read latency
// Ports: clk; addr = {character code, glyph row}; data = glyph row bits, bit 7 is the leftmost pixel.
// Glyphs are generated arithmetically: space and rows 0-1 / 14-15 are blank, other rows are
// {code,1} xor {row,row}, which is distinct for every printable code on every inked row.
module ascii_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);
    logic [6:0] code;
    logic [3:0] row;
    logic [7:0] glyph;

    assign code = addr[10:4];
    assign row  = addr[3:0];

    always_comb begin
        glyph = 8'h00;
        if (code != 7'h20 && row >= 4'd2 && row <= 4'd13)
            glyph = {code, 1'b1} ^ {row, row};
    end

    always_ff @(posedge clk)
        data <= glyph;

endmodule

// File: rtl/text_line_buffer.sv
// rtl/text_line_buffer.sv - character cell line with commit, backspace, clear and scroll/wrap
// Ports: clk, rst_n (sync, active low); letter/send from the decoder (send rising edge commits);
// clear empties the line; rd_col -> rd_char is a combinational read port; char_count, full.
// With MORSE_TEXT_CURSOR_EN defined, cursor_ptr exposes the write pointer.
module text_line_buffer import morse_text_pkg::*; #(
    parameter  int NUM_CHARS = 32,
    parameter  int FULL_MODE = 0,
    localparam int CW        = $clog2(NUM_CHARS),
    localparam int PW        = $clog2(NUM_CHARS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    letter,
    input  logic          send,
    input  logic          clear,
    input  logic [CW-1:0] rd_col,
    output logic [6:0]    rd_char,
`ifdef MORSE_TEXT_CURSOR_EN
    output logic [PW-1:0] cursor_ptr,
`endif
    output logic [PW-1:0] char_count,
    output logic          full
);
    logic [6:0]    cells [NUM_CHARS];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] ptr_dec;
    logic          send_q;
    logic          commit;

    assign commit  = send & ~send_q;
    assign full    = (char_count == PW'(NUM_CHARS));
    assign rd_char = cells[rd_col];
`ifdef MORSE_TEXT_CURSOR_EN
    assign cursor_ptr = wr_ptr;
`endif

    // In wrap mode the pointer moves modulo NUM_CHARS in both directions; in scroll
    // mode it tracks the count and parks at NUM_CHARS once the line is full.
    always_comb begin
        ptr_inc = wr_ptr + 1'b1;
        ptr_dec = wr_ptr - 1'b1;
        if (FULL_MODE != 0) begin
            if (wr_ptr == PW'(NUM_CHARS - 1))
                ptr_inc = '0;
            if (wr_ptr == '0)
                ptr_dec = PW'(NUM_CHARS - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++)
                cells[i] <= ASCII_SPACE;
            wr_ptr     <= '0;
            char_count <= '0;
            send_q     <= 1'b0;
        end else begin
            send_q <= send;
            if (clear) begin
                // A commit arriving with clear is dropped on purpose.
                for (int i = 0; i < NUM_CHARS; i++)
                    cells[i] <= ASCII_SPACE;
                wr_ptr     <= '0;
                char_count <= '0;
            end else if (commit) begin
                if (is_printable(letter)) begin
                    if (full && FULL_MODE == 0) begin
                        for (int i = 0; i < NUM_CHARS - 1; i++)
                            cells[i] <= cells[i+1];
                        cells[NUM_CHARS-1] <= letter[6:0];
                    end else begin
                        cells[CW'(wr_ptr)] <= letter[6:0];
                        wr_ptr             <= ptr_inc;
                        if (!full)
                            char_count <= char_count + 1'b1;
                    end
                end else if (letter == ASCII_BS && char_count != '0) begin
                    cells[CW'(ptr_dec)] <= ASCII_SPACE;
                    wr_ptr              <= ptr_dec;
                    char_count          <= char_count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/morse_text_line.sv
// rtl/morse_text_line.sv - renders a line of decoded Morse letters as 8x16 glyphs over VGA
// Ports: clk, rst_n (sync, active low); video_on, x, y from the sync generator; letter/send/clear
// from the decoder; rgb (registered, 3 clk after x/y/video_on); char_count; full.
// Optional: define MORSE_TEXT_CURSOR_EN for a blinking underscore cursor at the write position.
module morse_text_line import morse_text_pkg::*; #(
    parameter  int          NUM_CHARS = 32,
    parameter  int          ORIGIN_X  = 192,
    parameter  int          ORIGIN_Y  = 224,
    parameter  logic [11:0] FG_COLOR  = DEFAULT_FG,
    parameter  logic [11:0] BG_COLOR  = DEFAULT_BG,
    parameter  int          FULL_MODE = 0,
    localparam int          CW        = $clog2(NUM_CHARS),
    localparam int          PW        = $clog2(NUM_CHARS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          video_on,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic [7:0]    letter,
    input  logic          send,
    input  logic          clear,
    output logic [11:0]   rgb,
    output logic [PW-1:0] char_count,
    output logic          full
);
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + CHAR_W * NUM_CHARS);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + CHAR_H);

    logic [CW+2:0] dx;
    logic [3:0]    dy;
    logic          in_region;
    logic [CW-1:0] col;
    logic [6:0]    cell_char;
    logic          cursor_hit;

    logic [10:0]   rom_addr;
    logic [7:0]    rom_data;
    logic [2:0]    px_s1, px_s2;
    logic          reg_s1, reg_s2, von_s1, von_s2, cur_s1, cur_s2;

    // Only the low bits of the offsets are needed: dx up to the cell index, dy the glyph row.
    assign dx        = x[CW+2:0] - X_LO[CW+2:0];
    assign dy        = y[3:0] - Y_LO[3:0];
    assign in_region = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                       ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    assign col       = in_region ? dx[CW+2:3] : '0;

    text_line_buffer #(
        .NUM_CHARS (NUM_CHARS),
        .FULL_MODE (FULL_MODE)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .letter     (letter),
        .send       (send),
        .clear      (clear),
        .rd_col     (col),
        .rd_char    (cell_char),
`ifdef MORSE_TEXT_CURSOR_EN
        .cursor_ptr (cursor_ptr),
`endif
        .char_count (char_count),
        .full       (full)
    );

`ifdef MORSE_TEXT_CURSOR_EN
    logic [PW-1:0] cursor_ptr;
    logic [5:0]    frame_cnt;
    logic          origin_q;

    // Count frames on the first cycle of pixel (0,0); x/y are held for several clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            origin_q  <= 1'b0;
        end else begin
            origin_q <= (x == '0) && (y == '0);
            if ((x == '0) && (y == '0) && !origin_q)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign cursor_hit = frame_cnt[5] && in_region && (PW'(col) == cursor_ptr) &&
                        (dy[3:1] == 3'b111) && !(full && FULL_MODE == 0);
`else
    assign cursor_hit = 1'b0;
`endif

    ascii_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
            px_s1    <= '0;
            px_s2    <= '0;
            reg_s1   <= 1'b0;
            reg_s2   <= 1'b0;
            von_s1   <= 1'b0;
            von_s2   <= 1'b0;
            cur_s1   <= 1'b0;
            cur_s2   <= 1'b0;
            rgb      <= COLOR_BLACK;
        end else begin
            rom_addr <= {cell_char, dy};
            px_s1    <= dx[2:0];
            reg_s1   <= in_region;
            von_s1   <= video_on;
            cur_s1   <= cursor_hit;
            px_s2    <= px_s1;
            reg_s2   <= reg_s1;
            von_s2   <= von_s1;
            cur_s2   <= cur_s1;
            if (!von_s2)
                rgb <= COLOR_BLACK;
            else if (reg_s2 && (rom_data[~px_s2] || cur_s2))
                rgb <= FG_COLOR;
            else
                rgb <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_morse_text_line.sv
// tb/tb_morse_text_line.sv - self-checking bench for morse_text_line
module tb_morse_text_line;

    localparam logic [11:0] FG = 12'h00F;
    localparam logic [11:0] BG = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst_n, video_on, send, clear;
    logic [9:0]  x, y;
    logic [7:0]  letter;
    logic [11:0] rgb_b, rgb_4s, rgb_4w;
    logic [5:0]  cnt_b;
    logic [2:0]  cnt_4s, cnt_4w;
    logic        full_b, full_4s, full_4w;

    always #5 clk = ~clk;

    morse_text_line u_big (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y), .letter(letter),
        .send(send), .clear(clear), .rgb(rgb_b), .char_count(cnt_b), .full(full_b));

    morse_text_line #(.NUM_CHARS(4), .FULL_MODE(0)) u_scroll (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y), .letter(letter),
        .send(send), .clear(clear), .rgb(rgb_4s), .char_count(cnt_4s), .full(full_4s));

    morse_text_line #(.NUM_CHARS(4), .FULL_MODE(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y), .letter(letter),
        .send(send), .clear(clear), .rgb(rgb_4w), .char_count(cnt_4w), .full(full_4w));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: scroll lines are queues trimmed from the front, the wrap line is a
    // circular array with a pointer and a saturating count.
    logic [7:0] q_b[$];
    logic [7:0] q_4s[$];
    logic [7:0] w_cells[4];
    int         w_ptr, w_cnt;

    function automatic bit printable(input logic [7:0] c);
        return c >= 8'h20 && c <= 8'h7E;
    endfunction

    task automatic model_send(input logic [7:0] c);
        if (printable(c)) begin
            q_b.push_back(c);
            if (q_b.size() > 32) void'(q_b.pop_front());
            q_4s.push_back(c);
            if (q_4s.size() > 4) void'(q_4s.pop_front());
            w_cells[w_ptr] = c;
            w_ptr = (w_ptr + 1) % 4;
            if (w_cnt < 4) w_cnt++;
        end else if (c == 8'h08) begin
            if (q_b.size() > 0) void'(q_b.pop_back());
            if (q_4s.size() > 0) void'(q_4s.pop_back());
            if (w_cnt > 0) begin
                w_ptr = (w_ptr + 3) % 4;
                w_cells[w_ptr] = 8'h20;
                w_cnt--;
            end
        end
    endtask

    task automatic model_clear();
        q_b.delete();
        q_4s.delete();
        for (int i = 0; i < 4; i++) w_cells[i] = 8'h20;
        w_ptr = 0;
        w_cnt = 0;
    endtask

    function automatic string model_str(input int inst);
        string s = "";
        if (inst == 0)
            foreach (q_b[i]) s = {s, $sformatf("%c", q_b[i])};
        else if (inst == 1)
            foreach (q_4s[i]) s = {s, $sformatf("%c", q_4s[i])};
        else
            for (int i = 0; i < 4; i++) s = {s, $sformatf("%c", w_cells[i])};
        return s;
    endfunction

    function automatic int glyph(input int ch, input int row);
        if (ch == 32 || row < 2 || row > 13) return 0;
        return ((ch * 2 + 1) ^ (row * 17)) & 255;
    endfunction

    function automatic logic [11:0] exp_px(input int n, input string s, input int xx,
                                           input int yy, input bit von);
        int dx, dy, ci, ch;
        dx = xx - 192;
        dy = yy - 224;
        if (!von) return 12'h000;
        if (dx < 0 || dx >= 8 * n || dy < 0 || dy >= 16) return BG;
        ci = dx / 8;
        ch = (ci < s.len()) ? int'(s[ci]) : 32;
        return ((glyph(ch, dy) >> (7 - dx % 8)) & 1) != 0 ? FG : BG;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic px(input string nm, input int xx, input int yy, input bit von,
                      input string sb, input string s0, input string s1);
        x = xx[9:0];
        y = yy[9:0];
        video_on = von;
        repeat (4) @(negedge clk);
        chk({nm, "/rgb32"},  int'(rgb_b),  int'(exp_px(32, sb, xx, yy, von)));
        chk({nm, "/rgb4s"},  int'(rgb_4s), int'(exp_px(4,  s0, xx, yy, von)));
        chk({nm, "/rgb4w"},  int'(rgb_4w), int'(exp_px(4,  s1, xx, yy, von)));
    endtask

    task automatic scan(input string sb, input string s0, input string s1);
        for (int yy = 224; yy < 240; yy++)
            for (int xx = 188; xx < 232; xx++)
                px("scan", xx, yy, 1'b1, sb, s0, s1);
    endtask

    task automatic chk_counts(input string nm, input int cb, input int c0, input int c1);
        chk({nm, "/cnt32"},  int'(cnt_b),   cb);
        chk({nm, "/cnt4s"},  int'(cnt_4s),  c0);
        chk({nm, "/cnt4w"},  int'(cnt_4w),  c1);
        chk({nm, "/full32"}, int'(full_b),  int'(cb == 32));
        chk({nm, "/full4s"}, int'(full_4s), int'(c0 == 4));
        chk({nm, "/full4w"}, int'(full_4w), int'(c1 == 4));
    endtask

    task automatic op_send(input logic [7:0] c);
        letter = c;
        send = 1'b1;
        repeat (2) @(negedge clk);
        send = 1'b0;
        repeat (2) @(negedge clk);
        model_send(c);
    endtask

    task automatic op_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        model_clear();
    endtask

    typedef struct {
        bit         is_clear;
        logic [7:0] ch;
        int         cb, c0, c1;
        bit         do_scan;
        string      sb, s0, s1;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit is_clr, input logic [7:0] ch, input int cb, input int c0,
                       input int c1, input bit sc, input string sb, input string s0,
                       input string s1);
        vec_t v;
        v.is_clear = is_clr; v.ch = ch; v.cb = cb; v.c0 = c0; v.c1 = c1;
        v.do_scan = sc; v.sb = sb; v.s0 = s0; v.s1 = s1;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; video_on = 1'b0; send = 1'b0; clear = 1'b0;
        x = '0; y = '0; letter = '0;
        model_clear();

        add(0, 8'h53, 1, 1, 1, 0, "", "", "");
        add(0, 8'h4F, 2, 2, 2, 0, "", "", "");
        add(0, 8'h53, 3, 3, 3, 1, "SOS", "SOS", "SOS ");
        add(1, 8'h00, 0, 0, 0, 0, "", "", "");
        add(0, 8'h08, 0, 0, 0, 0, "", "", "");
        add(0, 8'h41, 1, 1, 1, 0, "", "", "");
        add(0, 8'h08, 0, 0, 0, 1, "", "", "    ");
        add(0, 8'h41, 1, 1, 1, 0, "", "", "");
        add(0, 8'h42, 2, 2, 2, 0, "", "", "");
        add(0, 8'h43, 3, 3, 3, 0, "", "", "");
        add(0, 8'h44, 4, 4, 4, 0, "", "", "");
        add(0, 8'h45, 5, 4, 4, 1, "ABCDE", "BCDE", "EBCD");
        add(0, 8'h85, 5, 4, 4, 0, "", "", "");
        add(0, 8'h7F, 5, 4, 4, 0, "", "", "");
        add(0, 8'h08, 4, 3, 3, 1, "ABCD", "BCD", " BCD");
        add(0, 8'h46, 5, 4, 4, 0, "", "", "");
        add(0, 8'h20, 6, 4, 4, 0, "", "", "");
        add(0, 8'h7E, 7, 4, 4, 1, "ABCDF ~", "DF ~", "F ~D");

        repeat (3) @(negedge clk);
        chk("reset/rgb32", int'(rgb_b), 0);
        chk("reset/rgb4w", int'(rgb_4w), 0);
        chk_counts("reset", 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            if (tbl[i].is_clear) op_clear();
            else op_send(tbl[i].ch);
            chk_counts($sformatf("vec%0d", i), tbl[i].cb, tbl[i].c0, tbl[i].c1);
            if (tbl[i].do_scan) scan(tbl[i].sb, tbl[i].s0, tbl[i].s1);
        end

        // Region edges and video blanking, line is "ABCDF ~" / "DF ~" / "F ~D"
        px("above",     200, 223, 1'b1, "ABCDF ~", "DF ~", "F ~D");
        px("below",     200, 240, 1'b1, "ABCDF ~", "DF ~", "F ~D");
        px("left",      191, 230, 1'b1, "ABCDF ~", "DF ~", "F ~D");
        px("lastcell",  447, 230, 1'b1, "ABCDF ~", "DF ~", "F ~D");
        px("right",     448, 230, 1'b1, "ABCDF ~", "DF ~", "F ~D");
        px("von0",      194, 230, 1'b0, "ABCDF ~", "DF ~", "F ~D");

        // Three-clock latency from video_on to rgb
        x = 10'd188; y = 10'd230; video_on = 1'b0;
        repeat (4) @(negedge clk);
        video_on = 1'b1;
        @(negedge clk); chk("lat1", int'(rgb_b), 0);
        @(negedge clk); chk("lat2", int'(rgb_b), 0);
        @(negedge clk); chk("lat3", int'(rgb_b), int'(BG));

        // Send held high for 100 clocks commits once
        op_clear();
        letter = 8'h5A;
        send = 1'b1;
        repeat (100) @(negedge clk);
        send = 1'b0;
        repeat (2) @(negedge clk);
        model_send(8'h5A);
        chk_counts("hold", 1, 1, 1);
        px("hold_px", 196, 230, 1'b1, model_str(0), model_str(1), model_str(2));

        // Clear wins over a same-cycle commit
        op_send(8'h58);
        chk_counts("pre_clr", 2, 2, 2);
        letter = 8'h51;
        send = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        send = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
        chk_counts("clr_send", 0, 0, 0);
        for (int xx = 192; xx < 208; xx++)
            px("clr_px", xx, 231, 1'b1, "", "", "    ");

        // Reset in the middle of a visible line
        op_send(8'h52);
        x = 10'd200; y = 10'd230; video_on = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_clear();
        chk("mrst/rgb32", int'(rgb_b), 0);
        chk("mrst/rgb4s", int'(rgb_4s), 0);
        chk_counts("mrst", 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk); chk("mrst_fill1", int'(rgb_b), 0);
        @(negedge clk); chk("mrst_fill2", int'(rgb_b), 0);
        @(negedge clk); chk("mrst_fill3", int'(rgb_b), int'(BG));

        // Random traffic against the model
        for (int it = 0; it < 200; it++) begin
            int r;
            logic [7:0] c;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                op_clear();
            end else begin
                if (r < 20) c = 8'h08;
                else if (r < 25) c = 8'($urandom_range(128, 255));
                else if (r < 30) c = 8'($urandom_range(0, 7));
                else c = 8'($urandom_range(32, 126));
                op_send(c);
            end
            chk_counts($sformatf("rnd%0d", it), q_b.size(), q_4s.size(), w_cnt);
            if (it % 20 == 19) begin
                for (int k = 0; k < 10; k++)
                    px($sformatf("rpx%0d_%0d", it, k), $urandom_range(180, 460),
                       $urandom_range(220, 243), $urandom_range(0, 9) != 0,
                       model_str(0), model_str(1), model_str(2));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
